// File: rtl/key_motion_ctrl.sv
// Per-player horizontal velocity and jump-arc controller, advanced once per video frame.
// Two identical, independent player channels sit behind the key_motion_ctrl top.

module KeyMotionPlayer #(
    parameter int X_SPEED     = 2,
    parameter int JUMP_FRAMES = 16,
    parameter int JUMP_STEP   = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       jump_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [9:0] xvel_o,
    output logic [9:0] height_o,
    output logic [1:0] jstate_o,
    output logic       jpulse_o
);

    localparam int CW = $clog2(JUMP_FRAMES) + 1;
    localparam logic [9:0]    SPEED = 10'(X_SPEED);
    localparam logic [9:0]    STEP  = 10'(JUMP_STEP);
    localparam logic [CW-1:0] LAST  = CW'(JUMP_FRAMES - 1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jstate_e;

    jstate_e       state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]    height_q, height_d;
    logic [9:0]    xvel_q, xvel_d;
    logic          jumpPrev_q, jumpPrev_d;
    logic          jpulse_q, jpulse_d;
    logic          jumpEdge;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= GROUND;
            count_q    <= '0;
            height_q   <= '0;
            xvel_q     <= '0;
            jumpPrev_q <= 1'b0;
            jpulse_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            height_q   <= height_d;
            xvel_q     <= xvel_d;
            jumpPrev_q <= jumpPrev_d;
            jpulse_q   <= jpulse_d;
        end
    end

    // The turnover tick holds the height so the arc peaks at exactly JUMP_FRAMES*JUMP_STEP.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        height_d   = height_q;
        xvel_d     = xvel_q;
        jumpPrev_d = jumpPrev_q;
        jpulse_d   = 1'b0;
        jumpEdge   = jump_i & ~jumpPrev_q;

        if (frame_tick_i) begin
            jumpPrev_d = jump_i;

            if (left_i && !right_i) begin
                xvel_d = 10'd0 - SPEED;
            end else if (right_i && !left_i) begin
                xvel_d = SPEED;
            end else begin
                xvel_d = '0;
            end

            case (state_q)
                GROUND: begin
                    count_d  = '0;
                    height_d = '0;
                    if (jumpEdge) begin
                        state_d  = RISE;
                        height_d = STEP;
                        jpulse_d = 1'b1;
                    end
                end
                RISE: begin
                    if (count_q == LAST) begin
                        state_d = FALL;
                        count_d = '0;
                    end else begin
                        height_d = height_q + STEP;
                        count_d  = count_q + 1'b1;
                    end
                end
                FALL: begin
                    // Landing forces zero so the height can never wrap below ground.
                    if (count_q == LAST) begin
                        state_d  = GROUND;
                        count_d  = '0;
                        height_d = '0;
                    end else begin
                        height_d = height_q - STEP;
                        count_d  = count_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = GROUND;
                    count_d  = '0;
                    height_d = '0;
                end
            endcase
        end
    end

    assign xvel_o   = xvel_q;
    assign height_o = height_q;
    assign jstate_o = state_q;
    assign jpulse_o = jpulse_q;

endmodule

module key_motion_ctrl #(
    parameter int X_SPEED     = 2,
    parameter int JUMP_FRAMES = 16,
    parameter int JUMP_STEP   = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_tick_i,
    input  logic       w_on_i,
    input  logic       a_on_i,
    input  logic       d_on_i,
    input  logic       up_on_i,
    input  logic       left_on_i,
    input  logic       right_on_i,
    output logic [9:0] p1_xvel_o,
    output logic [9:0] p2_xvel_o,
    output logic [9:0] p1_height_o,
    output logic [9:0] p2_height_o,
    output logic [1:0] p1_jstate_o,
    output logic [1:0] p2_jstate_o,
    output logic       p1_jpulse_o,
    output logic       p2_jpulse_o
);

    KeyMotionPlayer #(
        .X_SPEED    (X_SPEED),
        .JUMP_FRAMES(JUMP_FRAMES),
        .JUMP_STEP  (JUMP_STEP)
    ) player1 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .frame_tick_i(frame_tick_i),
        .jump_i      (w_on_i),
        .left_i      (a_on_i),
        .right_i     (d_on_i),
        .xvel_o      (p1_xvel_o),
        .height_o    (p1_height_o),
        .jstate_o    (p1_jstate_o),
        .jpulse_o    (p1_jpulse_o)
    );

    KeyMotionPlayer #(
        .X_SPEED    (X_SPEED),
        .JUMP_FRAMES(JUMP_FRAMES),
        .JUMP_STEP  (JUMP_STEP)
    ) player2 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .frame_tick_i(frame_tick_i),
        .jump_i      (up_on_i),
        .left_i      (left_on_i),
        .right_i     (right_on_i),
        .xvel_o      (p2_xvel_o),
        .height_o    (p2_height_o),
        .jstate_o    (p2_jstate_o),
        .jpulse_o    (p2_jpulse_o)
    );

endmodule

// File: tb/tb_key_motion_ctrl.sv
// Directed bench for key_motion_ctrl: velocity decode, jump arc, edge detection and reset.
// Expected values are hand-derived from the default parameters (speed 2, 16 frames, step 3).

module tb_key_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frameTick;
    logic       wOn, aOn, dOn, upOn, leftOn, rightOn;
    logic [9:0] p1Xvel, p2Xvel, p1Height, p2Height;
    logic [1:0] p1Jstate, p2Jstate;
    logic       p1Jpulse, p2Jpulse;

    int compared   = 0;
    int mismatched = 0;

    key_motion_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .frame_tick_i(frameTick),
        .w_on_i      (wOn),
        .a_on_i      (aOn),
        .d_on_i      (dOn),
        .up_on_i     (upOn),
        .left_on_i   (leftOn),
        .right_on_i  (rightOn),
        .p1_xvel_o   (p1Xvel),
        .p2_xvel_o   (p2Xvel),
        .p1_height_o (p1Height),
        .p2_height_o (p2Height),
        .p1_jstate_o (p1Jstate),
        .p2_jstate_o (p2Jstate),
        .p1_jpulse_o (p1Jpulse),
        .p2_jpulse_o (p2Jpulse)
    );

    always #5 clk = ~clk;

    // keys = {w, a, d, up, left, right}; one frame tick, outputs sampled on the following negedge
    task automatic applyStimulus(input logic [5:0] keys);
        @(negedge clk);
        {wOn, aOn, dOn, upOn, leftOn, rightOn} = keys;
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle1();
        checkOutput("p1_xvel_idle",   32'(p1Xvel),   32'h0);
        checkOutput("p1_height_idle", 32'(p1Height), 32'h0);
        checkOutput("p1_jstate_idle", 32'(p1Jstate), 32'h0);
        checkOutput("p1_jpulse_idle", 32'(p1Jpulse), 32'h0);
    endtask

    task automatic checkIdle2();
        checkOutput("p2_xvel_idle",   32'(p2Xvel),   32'h0);
        checkOutput("p2_height_idle", 32'(p2Height), 32'h0);
        checkOutput("p2_jstate_idle", 32'(p2Jstate), 32'h0);
        checkOutput("p2_jpulse_idle", 32'(p2Jpulse), 32'h0);
    endtask

    localparam logic [5:0] K_NONE  = 6'b000000;
    localparam logic [5:0] K_W     = 6'b100000;
    localparam logic [5:0] K_A     = 6'b010000;
    localparam logic [5:0] K_AD    = 6'b011000;
    localparam logic [5:0] K_UP    = 6'b000100;
    localparam logic [5:0] K_RIGHT = 6'b000001;
    localparam logic [5:0] K_WUP   = 6'b100100;

    initial begin
        reset = 1'b1;
        frameTick = 1'b0;
        {wOn, aOn, dOn, upOn, leftOn, rightOn} = K_NONE;
        repeat (3) @(negedge clk);
        checkIdle1();
        checkIdle2();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(K_NONE);
            checkIdle1();
            checkIdle2();
        end

        // Horizontal velocity
        for (int i = 0; i < 3; i++) begin
            applyStimulus(K_A);
            checkOutput("p1_xvel_left", 32'(p1Xvel), 32'h3FE);
        end
        applyStimulus(K_AD);
        checkOutput("p1_xvel_both", 32'(p1Xvel), 32'h0);
        applyStimulus(K_RIGHT);
        checkOutput("p2_xvel_right", 32'(p2Xvel), 32'h2);
        checkOutput("p1_xvel_unaff", 32'(p1Xvel), 32'h0);
        applyStimulus(K_NONE);
        checkOutput("p2_xvel_release", 32'(p2Xvel), 32'h0);

        // Single tapped jump: full 32-tick arc
        applyStimulus(K_W);
        checkOutput("p1_jpulse_start", 32'(p1Jpulse), 32'h1);
        checkOutput("p1_height_start", 32'(p1Height), 32'd3);
        checkOutput("p1_jstate_start", 32'(p1Jstate), 32'd1);
        @(negedge clk);
        checkOutput("p1_jpulse_one_cycle", 32'(p1Jpulse), 32'h0);
        for (int n = 1; n <= 32; n++) begin
            applyStimulus(K_NONE);
            checkOutput("p1_jpulse_arc", 32'(p1Jpulse), 32'h0);
            if (n <= 15) begin
                checkOutput("p1_height_rise", 32'(p1Height), 32'(3 + 3 * n));
                checkOutput("p1_jstate_rise", 32'(p1Jstate), 32'd1);
            end else if (n == 16) begin
                checkOutput("p1_height_peak", 32'(p1Height), 32'd48);
                checkOutput("p1_jstate_peak", 32'(p1Jstate), 32'd2);
            end else if (n <= 31) begin
                checkOutput("p1_height_fall", 32'(p1Height), 32'(48 - 3 * (n - 16)));
                checkOutput("p1_jstate_fall", 32'(p1Jstate), 32'd2);
            end else begin
                checkOutput("p1_height_land", 32'(p1Height), 32'd0);
                checkOutput("p1_jstate_land", 32'(p1Jstate), 32'd0);
            end
        end

        // Held jump key: one pulse only, then release/press retriggers
        applyStimulus(K_W);
        checkOutput("p1_jpulse_held_start", 32'(p1Jpulse), 32'h1);
        for (int n = 1; n <= 42; n++) begin
            applyStimulus(K_W);
            checkOutput("p1_jpulse_held", 32'(p1Jpulse), 32'h0);
        end
        checkOutput("p1_jstate_held_landed", 32'(p1Jstate), 32'd0);
        applyStimulus(K_NONE);
        checkOutput("p1_jpulse_released", 32'(p1Jpulse), 32'h0);
        applyStimulus(K_W);
        checkOutput("p1_jpulse_repress", 32'(p1Jpulse), 32'h1);
        checkOutput("p1_jstate_repress", 32'(p1Jstate), 32'd1);

        // Mid-rise reset coincident with a frame tick
        for (int n = 1; n <= 7; n++) applyStimulus(K_NONE);
        checkOutput("p1_height_midrise", 32'(p1Height), 32'd24);
        @(negedge clk);
        reset = 1'b1;
        frameTick = 1'b1;
        {wOn, aOn, dOn, upOn, leftOn, rightOn} = K_A;
        @(negedge clk);
        reset = 1'b0;
        frameTick = 1'b0;
        {wOn, aOn, dOn, upOn, leftOn, rightOn} = K_NONE;
        checkOutput("p1_height_reset", 32'(p1Height), 32'd0);
        checkOutput("p1_jstate_reset", 32'(p1Jstate), 32'd0);
        checkOutput("p1_xvel_reset",   32'(p1Xvel),   32'd0);

        // Player 2: press during FALL held through landing must not relaunch
        applyStimulus(K_UP);
        checkOutput("p2_jpulse_start", 32'(p2Jpulse), 32'h1);
        checkIdle1();
        for (int n = 1; n <= 16; n++) applyStimulus(K_NONE);
        checkOutput("p2_jstate_fall", 32'(p2Jstate), 32'd2);
        for (int n = 17; n <= 36; n++) begin
            applyStimulus(K_UP);
            checkOutput("p2_jpulse_airborne_press", 32'(p2Jpulse), 32'h0);
        end
        checkOutput("p2_jstate_landed", 32'(p2Jstate), 32'd0);
        checkOutput("p2_height_landed", 32'(p2Height), 32'd0);
        applyStimulus(K_NONE);
        applyStimulus(K_UP);
        checkOutput("p2_jpulse_repress", 32'(p2Jpulse), 32'h1);
        checkOutput("p2_height_repress", 32'(p2Height), 32'd3);

        // Keys held across reset release: both players jump together on the first tick
        @(negedge clk);
        reset = 1'b1;
        {wOn, aOn, dOn, upOn, leftOn, rightOn} = K_WUP;
        @(negedge clk);
        checkIdle2();
        reset = 1'b0;
        applyStimulus(K_WUP);
        checkOutput("p1_jpulse_simul", 32'(p1Jpulse), 32'h1);
        checkOutput("p2_jpulse_simul", 32'(p2Jpulse), 32'h1);
        checkOutput("p1_height_simul", 32'(p1Height), 32'd3);
        checkOutput("p2_height_simul", 32'(p2Height), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
